// File: rtl/cat_pkg.sv
// Shared constants and FSM state type for the category histogram.
package cat_pkg;

   localparam int NUM_CAT = 16;
   localparam int CAT_W   = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      DUMP = 1'b1
   } state_e;

endpackage

// File: rtl/cat_hist_bin.sv
// One histogram bin counter; clear beats increment.
// Define CAT_HIST_SAT_EN to saturate at all-ones instead of wrapping to zero.
module cat_hist_bin #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear, then increment (saturating or wrapping), else hold.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
`ifdef CAT_HIST_SAT_EN
         if (count_q == {CNT_W{1'b1}}) begin
            count_d = count_q;
         end else begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
`else
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cat_hist.sv
// 16-bin category histogram with clear-on-read streaming dump.
// Optional macro CAT_HIST_SAT_EN selects saturating bins (see cat_hist_bin).
module cat_hist
   import cat_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CAT_W-1:0] cat,
   input  logic             cat_vld,
   output logic             cat_rdy,
   input  logic             dump_req,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [CAT_W-1:0] out_idx,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_last,
   output logic             busy
);

   state_e           state_q;
   state_e           state_d;
   logic [CAT_W-1:0] idx_q;
   logic [CAT_W-1:0] idx_d;
   logic [CNT_W-1:0] bin_cnt_s [NUM_CAT];
   logic             accept_s;
   logic             beat_s;
   logic             last_s;

   assign accept_s = cat_vld & (state_q == IDLE);
   assign beat_s   = out_rdy & (state_q == DUMP);
   assign last_s   = (idx_q == {CAT_W{1'b1}});

   // Next state and beat index.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (dump_req) begin
               state_d = DUMP;
               idx_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         DUMP: begin
            if (out_rdy) begin
               if (last_s) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + CAT_W'(1);
               end
            end else begin
               state_d = DUMP;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   for (genvar k = 0; k < NUM_CAT; k++) begin : g_bin
      localparam logic [CAT_W-1:0] K = CAT_W'(k);
      cat_hist_bin #(.CNT_W(CNT_W)) u_bin (
         .clk   (clk),
         .rst   (rst),
         .inc   (accept_s & (cat == K)),
         .clr   (beat_s & (idx_q == K)),
         .count (bin_cnt_s[k])
      );
   end

   assign cat_rdy  = (state_q == IDLE);
   assign out_vld  = (state_q == DUMP);
   assign busy     = (state_q == DUMP);
   assign out_idx  = idx_q;
   assign out_cnt  = out_vld ? bin_cnt_s[idx_q] : '0;
   assign out_last = out_vld & last_s;

endmodule

// File: tb/tb_cat_hist.sv
// Self-checking bench for cat_hist: vector table, directed dumps, randomized run vs a bin-array model.
module tb_cat_hist;

   logic        clk = 1'b0;
   logic        rst, cat_vld, dump_req, out_rdy;
   logic [3:0]  cat;

   logic        a_cat_rdy, a_out_vld, a_out_last, a_busy;
   logic [3:0]  a_out_idx;
   logic [15:0] a_out_cnt;
   logic        b_cat_rdy, b_out_vld, b_out_last, b_busy;
   logic [3:0]  b_out_idx;
   logic [1:0]  b_out_cnt;

   int checks = 0;
   int errors = 0;

   int m16 [16];
   int m2  [16];
   bit m_busy = 1'b0;
   int m_idx  = 0;
   int beats, beat_sum, cap;

   always #5 clk = ~clk;

   cat_hist #(.CNT_W(16)) dut16 (
      .clk(clk), .rst(rst), .cat(cat), .cat_vld(cat_vld), .cat_rdy(a_cat_rdy),
      .dump_req(dump_req), .out_vld(a_out_vld), .out_rdy(out_rdy), .out_idx(a_out_idx),
      .out_cnt(a_out_cnt), .out_last(a_out_last), .busy(a_busy)
   );

   cat_hist #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .cat(cat), .cat_vld(cat_vld), .cat_rdy(b_cat_rdy),
      .dump_req(dump_req), .out_vld(b_out_vld), .out_rdy(out_rdy), .out_idx(b_out_idx),
      .out_cnt(b_out_cnt), .out_last(b_out_last), .busy(b_busy)
   );

   typedef struct {
      bit       r;
      bit [3:0] c;
      bit       v, d, o;
      bit       e_rdy, e_vld;
      bit [3:0] e_idx;
      int       e_cnt;
      bit       e_last, e_busy;
   } vec_t;

   vec_t tbl [12];

   function automatic int bump(int v, int w);
      int mx;
      mx = (1 << w) - 1;
      if (v == mx) begin
`ifdef CAT_HIST_SAT_EN
         return mx;
`else
         return 0;
`endif
      end
      return v + 1;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_edge(bit r, bit [3:0] c, bit v, bit d, bit o);
      if (r) begin
         for (int i = 0; i < 16; i++) begin
            m16[i] = 0;
            m2[i]  = 0;
         end
         m_busy = 1'b0;
         m_idx  = 0;
      end else if (!m_busy) begin
         if (v) begin
            m16[c] = bump(m16[c], 16);
            m2[c]  = bump(m2[c], 2);
         end
         if (d) begin
            m_busy = 1'b1;
            m_idx  = 0;
         end
      end else if (o) begin
         m16[m_idx] = 0;
         m2[m_idx]  = 0;
         if (m_idx == 15) begin
            m_busy = 1'b0;
            m_idx  = 0;
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic compare_all();
      check("cat_rdy",  a_cat_rdy,  !m_busy);
      check("out_vld",  a_out_vld,  m_busy);
      check("busy",     a_busy,     m_busy);
      check("out_idx",  a_out_idx,  m_idx);
      check("out_cnt",  a_out_cnt,  m_busy ? m16[m_idx] : 0);
      check("out_last", a_out_last, m_busy && m_idx == 15);
      check("w2_cat_rdy", b_cat_rdy, !m_busy);
      check("w2_busy",    b_busy,    m_busy);
      check("w2_out_idx", b_out_idx, m_idx);
      check("w2_out_cnt", b_out_cnt, m_busy ? m2[m_idx] : 0);
      check("w2_out_last", b_out_last, m_busy && m_idx == 15);
   endtask

   task automatic step(bit r, bit [3:0] c, bit v, bit d, bit o);
      rst      = r;
      cat      = c;
      cat_vld  = v;
      dump_req = d;
      out_rdy  = o;
      if (!r && a_out_vld === 1'b1 && o) begin
         beats++;
         beat_sum += int'(a_out_cnt);
      end
      @(posedge clk);
      model_edge(r, c, v, d, o);
      #1;
      compare_all();
   endtask

   task automatic drain(int n, bit o_toggle);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 4'd0, 1'b0, 1'b0, o_toggle ? (k % 2 == 0) : 1'b1);
      end
   endtask

   initial begin
      //            r  c  v d o   rdy vld idx cnt last busy
      tbl[0]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 0, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 0, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 2, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 2, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 0, 1'b0, 1'b0};

      beats = 0;
      beat_sum = 0;
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].o);
         check($sformatf("tbl%0d_rdy", i),  a_cat_rdy,  tbl[i].e_rdy);
         check($sformatf("tbl%0d_vld", i),  a_out_vld,  tbl[i].e_vld);
         check($sformatf("tbl%0d_idx", i),  a_out_idx,  tbl[i].e_idx);
         check($sformatf("tbl%0d_cnt", i),  a_out_cnt,  tbl[i].e_cnt);
         check($sformatf("tbl%0d_last", i), a_out_last, tbl[i].e_last);
         check($sformatf("tbl%0d_busy", i), a_busy,     tbl[i].e_busy);
      end

      // Five samples of category 3, then a full-speed dump.
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 4'd3, 1'b1, 1'b0, 1'b1);
      beats = 0; beat_sum = 0;
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      drain(18, 1'b0);
      check("dump1_beats", beats, 16);
      check("dump1_sum", beat_sum, 5);
      check("dump1_busy_after", a_busy, 0);

      // Back-to-back dump reads all zeros.
      beats = 0; beat_sum = 0;
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      drain(18, 1'b0);
      check("dump2_beats", beats, 16);
      check("dump2_sum", beat_sum, 0);

      // Sample coincident with dump_req is counted; cat_vld during dump ignored.
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      beats = 0; beat_sum = 0;
      step(1'b0, 4'd7, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
         check("dump3_cat_rdy_low", a_cat_rdy, (k == 15) ? 1 : 0);
      end
      check("dump3_beats", beats, 16);
      check("dump3_sum", beat_sum, 1);

      // Stalled dump with out_rdy toggling.
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
      beats = 0; beat_sum = 0;
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      drain(40, 1'b1);
      check("dump4_beats", beats, 16);
      check("dump4_sum", beat_sum, 20);

      // Bin 1 incremented four times at width 2: saturate or wrap.
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      cap = -1;
      for (int k = 0; k < 18; k++) begin
         if (b_out_vld && b_out_idx == 4'd1) cap = int'(b_out_cnt);
         step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      end
`ifdef CAT_HIST_SAT_EN
      check("w2_bin1_sat", cap, 3);
`else
      check("w2_bin1_wrap", cap, 0);
`endif

      // Reset in the middle of a dump.
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      drain(6, 1'b0);
      check("abort_at_idx6", a_out_idx, 6);
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      check("abort_cat_rdy", a_cat_rdy, 1);
      check("abort_out_vld", a_out_vld, 0);
      beats = 0; beat_sum = 0;
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      drain(18, 1'b0);
      check("abort_dump_beats", beats, 16);
      check("abort_dump_sum", beat_sum, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
